// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcode encodings, data width and helpers for the RV32I ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int c_DATA_WIDTH = 32;

    // BEQ shares the SUB encoding; the branch is taken on a zero result.
    localparam logic [3:0] c_OP_ADD     = 4'b0000;
    localparam logic [3:0] c_OP_SUB     = 4'b1000;
    localparam logic [3:0] c_OP_BEQ     = 4'b1000;
    localparam logic [3:0] c_OP_SLL     = 4'b0001;
    localparam logic [3:0] c_OP_SRL     = 4'b0101;
    localparam logic [3:0] c_OP_SRL_ALT = 4'b1001;
    localparam logic [3:0] c_OP_SRA     = 4'b1101;
    localparam logic [3:0] c_OP_SLT     = 4'b0010;
    localparam logic [3:0] c_OP_SLTU    = 4'b0011;
    localparam logic [3:0] c_OP_XOR     = 4'b0100;
    localparam logic [3:0] c_OP_OR      = 4'b0110;
    localparam logic [3:0] c_OP_AND     = 4'b0111;
    localparam logic [3:0] c_OP_BNE     = 4'b1100;
    localparam logic [3:0] c_OP_BLT     = 4'b1010;
    localparam logic [3:0] c_OP_BGE     = 4'b1110;
    localparam logic [3:0] c_OP_BLTU    = 4'b1011;
    localparam logic [3:0] c_OP_BGEU    = 4'b1111;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shiftMode_e;

    function automatic logic [c_DATA_WIDTH-1:0] zeroExt(input logic bitIn);
        return {{(c_DATA_WIDTH-1){1'b0}}, bitIn};
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module   : alu_shifter
// Brief    : Combinational 5-stage barrel shifter (SLL / SRL / SRA).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shifter
    import alu_pkg::*;
(
    input  logic [c_DATA_WIDTH-1:0] iData,
    input  logic [4:0]              iShamt,
    input  shiftMode_e              iMode,
    output logic [c_DATA_WIDTH-1:0] oData
);

    logic                    wLeft;
    logic                    wFill;
    logic [c_DATA_WIDTH-1:0] wIn;
    logic [c_DATA_WIDTH-1:0] wStage [0:5];

    assign wLeft = (iMode == SHIFT_SLL);
    assign wFill = (iMode == SHIFT_SRA) & iData[c_DATA_WIDTH-1];

    // Left shifts reuse the right-shift network by mirroring bits in and out.
    for (genvar i = 0; i < c_DATA_WIDTH; i++) begin : g_rev
        assign wIn[i]   = wLeft ? iData[c_DATA_WIDTH-1-i]    : iData[i];
        assign oData[i] = wLeft ? wStage[5][c_DATA_WIDTH-1-i] : wStage[5][i];
    end

    assign wStage[0] = wIn;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        assign wStage[k+1] = iShamt[k]
            ? {{(1 << k){wFill}}, wStage[k][c_DATA_WIDTH-1:(1 << k)]}
            : wStage[k];
    end

endmodule

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Brief    : Single-cycle registered RV32I ALU with result and zero flag.
//            Macro ALU_BRANCH_EN enables the BNE/BLT/BGE/BLTU/BGEU opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iValid,
    input  logic [c_DATA_WIDTH-1:0] iDataA,
    input  logic [c_DATA_WIDTH-1:0] iDataB,
    input  logic [3:0]              iAluOp,
    output logic [c_DATA_WIDTH-1:0] oData,
    output logic                    oZero,
    output logic                    oValid
);

    logic [c_DATA_WIDTH-1:0] rData;
    logic                    rZero;
    logic                    rValid;

    logic                    wBLTU_output;
    logic                    wSignedLt;
    logic                    wNotEqual;
    logic [c_DATA_WIDTH-1:0] wSum;
    logic [c_DATA_WIDTH-1:0] wDiff;
    logic [c_DATA_WIDTH-1:0] wShifted;
    logic [c_DATA_WIDTH-1:0] wResult;
    shiftMode_e              wShiftMode;

    assign wBLTU_output = (iDataA < iDataB);
    assign wSignedLt    = ($signed(iDataA) < $signed(iDataB));
    assign wNotEqual    = (iDataA != iDataB);
    assign wSum         = iDataA + iDataB;
    assign wDiff        = iDataA - iDataB;

    always_comb begin
        wShiftMode = SHIFT_SRL;
        if (iAluOp == c_OP_SLL) begin
            wShiftMode = SHIFT_SLL;
        end else if (iAluOp == c_OP_SRA) begin
            wShiftMode = SHIFT_SRA;
        end
    end

    alu_shifter uShifter (
        .iData  (iDataA),
        .iShamt (iDataB[4:0]),
        .iMode  (wShiftMode),
        .oData  (wShifted)
    );

    always_comb begin
        wResult = '0;
        case (iAluOp)
            c_OP_ADD:               wResult = wSum;
            c_OP_SUB:               wResult = wDiff;
            c_OP_SLL,
            c_OP_SRL,
            c_OP_SRL_ALT,
            c_OP_SRA:               wResult = wShifted;
            c_OP_SLT:               wResult = zeroExt(wSignedLt);
            c_OP_SLTU:              wResult = zeroExt(wBLTU_output);
            c_OP_XOR:               wResult = iDataA ^ iDataB;
            c_OP_OR:                wResult = iDataA | iDataB;
            c_OP_AND:               wResult = iDataA & iDataB;
`ifdef ALU_BRANCH_EN
            c_OP_BNE:               wResult = zeroExt(wNotEqual);
            c_OP_BLT:               wResult = zeroExt(wSignedLt);
            c_OP_BGE:               wResult = zeroExt(~wSignedLt);
            c_OP_BLTU:              wResult = zeroExt(wBLTU_output);
            c_OP_BGEU:              wResult = zeroExt(~wBLTU_output);
`else
            c_OP_BNE,
            c_OP_BLT,
            c_OP_BGE,
            c_OP_BLTU,
            c_OP_BGEU:              wResult = '0;
`endif
            default:                wResult = '0;
        endcase
    end

`ifndef ALU_BRANCH_EN
    // Inequality only feeds BNE, which is absent in this build.
    logic wUnusedNe;
    assign wUnusedNe = wNotEqual;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rData  <= '0;
            rZero  <= 1'b1;
            rValid <= 1'b0;
        end else begin
            rValid <= iValid;
            if (iValid) begin
                rData <= wResult;
                rZero <= (wResult == '0);
            end
        end
    end

    assign oData  = rData;
    assign oZero  = rZero;
    assign oValid = rValid;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module   : tb_alu
// Brief    : Scoreboard-driven self-checking bench for the registered ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic [31:0] iDataA;
    logic [31:0] iDataB;
    logic [3:0]  iAluOp;
    logic [31:0] oData;
    logic        oZero;
    logic        oValid;

    int nChecks = 0;
    int nErrors = 0;
    logic [31:0] sbq [$];

    alu dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .iDataA (iDataA),
        .iDataB (iDataB),
        .iAluOp (iAluOp),
        .oData  (oData),
        .oZero  (oZero),
        .oValid (oValid)
    );

    always #5 iClk = ~iClk;

`ifdef ALU_BRANCH_EN
    localparam bit c_BR = 1'b1;
`else
    localparam bit c_BR = 1'b0;
`endif

    // Drive one op, record its expected result, advance past the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        iValid = 1'b1;
        iAluOp = op;
        iDataA = a;
        iDataB = b;
        sbq.push_back(exp);
        @(posedge iClk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        iRst = 1'b1; iValid = 1'b0; iAluOp = 4'h0; iDataA = '0; iDataB = '0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        exp = 32'h0;
        nChecks++;
        if (oData !== exp || oZero !== 1'b1 || oValid !== 1'b0) begin
            nErrors++;
            $display("FAIL reset: got data=%h zero=%b valid=%b, want data=%h zero=1 valid=0",
                     oData, oZero, oValid, exp);
        end
    endtask

    task automatic run_table(input string name, input logic [3:0] ops [],
                             input logic [31:0] as [], input logic [31:0] bs [],
                             input logic [31:0] exps []);
        logic [31:0] exp;
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i], as[i], bs[i], exps[i]);
            exp = sbq.pop_front();
            nChecks++;
            if (oData !== exp || oZero !== (exp == 32'h0) || oValid !== 1'b1) begin
                nErrors++;
                $display("FAIL %s[%0d] op=%b a=%h b=%h: got data=%h zero=%b valid=%b, want data=%h zero=%b valid=1",
                         name, i, ops[i], as[i], bs[i], oData, oZero, oValid, exp, (exp == 32'h0));
            end
        end
    endtask

    task automatic test_arith();
        run_table("arith",
            '{4'b0000, 4'b1000, 4'b1000, 4'b0000},
            '{32'd10, 32'd20, 32'd5, 32'hFFFF_FFFF},
            '{32'd5, 32'd7, 32'd5, 32'd1},
            '{32'd15, 32'd13, 32'd0, 32'd0});
    endtask

    task automatic test_shift();
        run_table("shift",
            '{4'b0001, 4'b0101, 4'b1101, 4'b0001, 4'b1001, 4'b1101, 4'b0001},
            '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'hF000_000F},
            '{32'd4, 32'd1, 32'd1, 32'h24, 32'd31, 32'd31, 32'd8},
            '{32'h10, 32'h4000_0000, 32'hC000_0000, 32'h10, 32'h1, 32'hFFFF_FFFF, 32'h0000_0F00});
    endtask

    task automatic test_compare();
        run_table("compare",
            '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0010},
            '{32'd5, 32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1},
            '{32'd10, 32'd5, 32'd1, 32'd1, 32'hFFFF_FFFF},
            '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0});
        iValid = 1'b0; iDataA = 32'd3; iDataB = 32'hFFFF_FFF0;
        #1;
        nChecks++;
        if (dut.wBLTU_output !== 1'b1) begin
            nErrors++;
            $display("FAIL bltu_probe: got %b, want 1", dut.wBLTU_output);
        end
    endtask

    task automatic test_branch();
        logic [31:0] e [10];
        e = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd1};
        if (!c_BR) begin
            for (int i = 0; i < 10; i++) e[i] = 32'd0;
        end
        run_table("branch",
            '{4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b1100, 4'b1110, 4'b1010, 4'b1110},
            '{32'd5, 32'd10, 32'd5, 32'd5, 32'd10, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5},
            '{32'd10, 32'd5, 32'd10, 32'd5, 32'd5, 32'd3, 32'd4, 32'd1, 32'd1, 32'd5},
            e);
    endtask

    task automatic test_logic();
        run_table("logic",
            '{4'b0111, 4'b0110, 4'b0100},
            '{32'hC, 32'hC, 32'hC},
            '{32'hA, 32'hA, 32'hA},
            '{32'h8, 32'hE, 32'h6});
    endtask

    task automatic test_hold();
        logic [31:0] exp;
        issue(4'b0000, 32'd10, 32'd5, 32'd15);
        exp = sbq.pop_front();
        iValid = 1'b0; iAluOp = 4'b1000; iDataA = 32'd7; iDataB = 32'd7;
        for (int i = 0; i < 2; i++) begin
            @(posedge iClk);
            #1;
            nChecks++;
            if (oData !== exp || oZero !== 1'b0 || oValid !== 1'b0) begin
                nErrors++;
                $display("FAIL hold[%0d]: got data=%h zero=%b valid=%b, want data=%h zero=0 valid=0",
                         i, oData, oZero, oValid, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        iRst = 1'b1; iValid = 1'b1; iAluOp = 4'b0000; iDataA = 32'd1; iDataB = 32'd1;
        @(posedge iClk);
        #1;
        iRst = 1'b0; iValid = 1'b0;
        nChecks++;
        if (oData !== 32'h0 || oZero !== 1'b1 || oValid !== 1'b0) begin
            nErrors++;
            $display("FAIL reset_priority: got data=%h zero=%b valid=%b, want data=0 zero=1 valid=0",
                     oData, oZero, oValid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            issue(4'b0000, a, b, a + b);
            exp = sbq.pop_front();
            nChecks++;
            if (oData !== exp || oZero !== (exp == 32'h0) || oValid !== 1'b1) begin
                nErrors++;
                $display("FAIL b2b[%0d]: got data=%h zero=%b valid=%b, want data=%h valid=1",
                         i, oData, oZero, oValid, exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arith();
        test_shift();
        test_compare();
        test_branch();
        test_logic();
        test_hold();
        test_reset_priority();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu.md
# alu

Single-cycle registered integer ALU for the RV32I datapath in the execute stage. Computes arithmetic, logic, shift, set-less-than and branch-compare results from two 32-bit operands under a 4-bit operation code. Drives a registered 32-bit result and zero flag consumed by writeback and branch resolution.

## Interface
- No parameters; data width fixed at 32.
- One clock, `iClk`. Reset `iRst` is synchronous and active-high.
- `iClk`  in  1  clock; all state updates on its rising edge
- `iRst`  in  1  synchronous active-high reset
- `iValid`  in  1  operands/op valid this cycle; register loads only when high
- `iDataA`  in  32  operand A (rs1)
- `iDataB`  in  32  operand B (rs2 or immediate); shift amount is `iDataB[4:0]`
- `iAluOp`  in  4  operation code
- `oData`  out  32  registered result
- `oZero`  out  1  registered, high when `oData` equals 0
- `oValid`  out  1  registered copy of `iValid`

## Operation
- Opcodes and results:
  - 0000 ADD: A+B, mod 2^32
  - 1000 SUB/BEQ: A−B, mod 2^32; BEQ taken when `oZero`=1
  - 0001 SLL: A << B[4:0]
  - 0101 and 1001 SRL: A >> B[4:0], zero fill
  - 1101 SRA: A >>> B[4:0], sign fill
  - 0010 SLT: 1 if signed A < signed B, else 0
  - 0011 SLTU: 1 if unsigned A < unsigned B, else 0
  - 0100 XOR, 0110 OR, 0111 AND: bitwise
  - 1100 BNE: 1 if A≠B
  - 1010 BLT: 1 if signed A < signed B
  - 1110 BGE: 1 if signed A ≥ signed B
  - 1011 BLTU: 1 if unsigned A < unsigned B
  - 1111 BGEU: 1 if unsigned A ≥ unsigned B
- Compare results zero-extended to 32 bits. Overflow and carry are discarded; no exceptions.
- Internal net `wBLTU_output` carries unsigned A<B. It exists under that name for bench probing. SLTU, BLTU and BGEU (inverted) all derive from it.
- `oZero` = (next `oData` == 0), registered together with `oData`.

## Timing
- Latency 1 cycle: inputs sampled at edge N when `iValid`=1; `oData`, `oZero` and `oValid`=1 are visible after edge N.
- `iValid`=0 at an edge: `oData` and `oZero` hold; `oValid` goes 0.
- Reset: `oData`=0, `oZero`=1, `oValid`=0. Reset takes priority over a simultaneous `iValid`.
- Back-to-back ops every cycle; no stalls, no backpressure.

## Configuration
- `ALU_BRANCH_EN` defined: opcodes 1100, 1010, 1110, 1011 and 1111 implement BNE/BLT/BGE/BLTU/BGEU as above.
- `ALU_BRANCH_EN` undefined: those five opcodes yield `oData`=0 and `oZero`=1.
- 1000 (SUB/BEQ) and all other opcodes are unaffected by the macro.

## Structure
- Shared package `alu_pkg`: 4-bit opcode constants (ADD, SUB, SLL, SRL, SRA, SLT, SLTU, XOR, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU) and the 32-bit data width constant.
- One sub-module `alu_shifter`: combinational barrel shifter taking A, shamt[4:0] and mode (SLL/SRL/SRA).
- Remaining logic is a combinational op mux feeding the output register.

## Test plan
- Reset, then ADD 10+5 → after 1 cycle `oData`=15, `oZero`=0, `oValid`=1. SUB 20−7 → 13. SUB 5−5 → 0 with `oZero`=1.
- Shifts: SLL 0x1<<4 → 0x10; SRL 0x80000000>>1 → 0x40000000; SRA 0x80000000>>1 → 0xC0000000; SLL with B=0x24 uses shamt 4 → 0x10.
- Compares: SLTU 5,10 → 1 and 10,5 → 0; SLT 0xFFFFFFFF,1 → 1; SLTU 0xFFFFFFFF,1 → 0.
- Branch ops with `ALU_BRANCH_EN` defined: BLTU 5,10 → 1; BLTU 10,5 → 0; BGEU 5,10 → 0; BGEU 5,5 → 1; BGEU 10,5 → 1; BNE 3,3 → 0; BGE 0xFFFFFFFF,1 → 0. Same opcodes without the macro → 0.
- Logic with A=0xC, B=0xA: AND → 0x8, OR → 0xE, XOR → 0x6.
- Handshake and reset:
  - `iValid`=0 for 2 cycles after an ADD → `oData` holds, `oValid`=0.
  - Assert `iRst` with `iValid`=1 → `oData`=0, `oZero`=1, `oValid`=0.
